fetch_multi: RTL and testbench
==============================

Name: fetch_multi

Overview:
Parametrised next-generation fetch address unit for the datapath.
- Generates ISSUE consecutive instruction addresses per fetch slot, with region tags, and selects redirect targets from N_SRC execute channels (jump-immediate or register-indirect).
- Buffers fetched addresses in a small queue with a valid/ready handshake toward decode, so decode back-pressure stalls the PC instead of dropping addresses.
- Sits between execute-stage redirect logic and the instruction memory/decode stage.

Parameters:
ADDR_W, 32, address width in bits.
N_SRC, 2, number of redirect source channels (>=1).
ISSUE, 2, addresses produced per entry (1..4); sequential step = 4*ISSUE bytes.
QDEPTH, 4, queue entries (power of 2, >=2).
RESET_PC, 0, PC value after reset and for sel_dir=11.
REGION_W, 4, upper address bits reported per slot as region tag.

Ports:
reloj  in  1  clock, all state on rising edge.
reset  in  1  synchronous, active-high reset.
sel_dir  in  2  00 sequential, 01 jump, 10 register target, 11 restart at RESET_PC.
sel_src  in  max(1,clog2(N_SRC))  redirect channel select.
jump_bus  in  N_SRC*ADDR_W  jump targets; channel k at bits [k*ADDR_W +: ADDR_W].
reg_bus  in  N_SRC*ADDR_W  register targets, same packing.
out_valid  out  1  queue head valid.
out_ready  in  1  decode accepts head.
out_pc  out  ADDR_W  head address (slot 0).
out_addr  out  ISSUE*ADDR_W  slot i = out_pc + 4*i, modulo 2^ADDR_W.
out_region  out  ISSUE*REGION_W  slot i = top REGION_W bits of slot i address.
align_err  out  1  one-cycle pulse: redirect target was misaligned.

Behaviour:
- Reset: PC=RESET_PC, queue empty (count=0), out_valid=0, align_err=0. out_pc/out_addr/out_region are don't-care while out_valid=0; they read as 0 after reset.
- pop = out_valid & out_ready.
- push_ok = (count<QDEPTH) | pop. A push on a full queue is allowed only when a pop happens in the same cycle.
- Sequential cycle (sel_dir=00):
  - If push_ok: enqueue the PC, then PC <= PC + 4*ISSUE, wrapping modulo 2^ADDR_W.
  - Otherwise PC holds and nothing is enqueued.
- Redirect cycle (sel_dir!=00):
  - Queue is flushed (count=0 after the edge). A handshake in this cycle counts as consumed, but no entry survives.
  - No push this cycle. PC <= target, where target = jump_bus[sel_src] (01), reg_bus[sel_src] (10), or RESET_PC (11).
  - If sel_src >= N_SRC, channel 0 is used.
  - Target bits [1:0] are forced to 0. If they were nonzero, align_err=1 for exactly the next cycle.
  - sel_dir=11 never raises align_err.
- Latency:
  - First sequential edge after reset or redirect pushes an entry; out_valid=1 after that edge.
  - Redirect-to-new-head latency = 2 edges.
  - Steady state with out_ready=1: one entry per cycle, no bubbles.
- Queue: registered head (no combinational path from sel_dir or buses to outputs). count stays in 0..QDEPTH. Pointers wrap modulo QDEPTH.
- Reset asserted mid-operation overrides redirect and handshake. Entries in flight are discarded.
- Consecutive redirects: the last one wins, and the queue stays empty until the first sequential cycle.

Decomposition:
- Shared package fetch_pkg holds:
  - sel_dir encodings SEL_SEQ=2'b00, SEL_JUMP=2'b01, SEL_REG=2'b10, SEL_RST=2'b11;
  - INSTR_BYTES=4;
  - the clog2 helper function.
- Sub-module fetch_fifo: synchronous FIFO, parametrised by WIDTH and DEPTH, with a flush input, push/pop, count, and registered head. Used for PC storage.
- Top level holds the PC register, the target mux, alignment check, and slot/region expansion.

Test Plan:
- Reset, then sequential with out_ready=1 (ISSUE=2):
  - out_valid rises one cycle after reset drops;
  - out_pc sequence 0x0, 0x8, 0x10, 0x18;
  - out_addr slot1 = 0x4, 0xC, ...
- Back-pressure: out_ready=0 for 8 cycles:
  - queue holds 4 entries (0x0–0x18), PC stalls at 0x20, out_pc stays 0x0;
  - on release, heads are 0x0, 0x8, 0x10, 0x18, 0x20 with no gaps or duplicates.
- Jump, sel_dir=01, sel_src=1, jump_bus ch1=0x1000_0040:
  - out_valid=0 for one cycle;
  - then out_pc=0x1000_0040, out_region slot0=0x1, then 0x1000_0048.
- Misaligned register redirect, sel_dir=10, reg_bus ch0=0x0000_0203:
  - align_err high exactly one cycle;
  - next head out_pc=0x0000_0200.
- Wrap-around: jump to 0xFFFF_FFF8:
  - out_addr = {0xFFFF_FFF8, 0xFFFF_FFFC}, region 0xF;
  - next head 0x0000_0000, region 0x0.
- Reset asserted while queue is full and sel_dir=01:
  - next cycle out_valid=0, align_err=0;
  - after release, out_pc=RESET_PC; sel_dir=11 mid-stream likewise restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: sel_dir encodings, instruction size and clog2 helper shared by the fetch unit
package fetch_pkg;
  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JUMP = 2'b01;
  localparam logic [1:0] SEL_REG  = 2'b10;
  localparam logic [1:0] SEL_RST  = 2'b11;
  localparam int INSTR_BYTES = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO with flush and registered storage (clk/rst, flush/push/pop/din in, head/count out)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        head,
  output logic [clog2(DEPTH):0]   count
);
  localparam int PW = clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop & (cnt_q != '0);
    do_push = push & ((cnt_q != (PW+1)'(DEPTH)) | do_pop);
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      if (do_push) mem_d[wr_q] = din;
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_multi.sv
// fetch_multi: multi-issue fetch PC generator with redirect mux and decode queue (reloj/reset, sel_dir/sel_src/jump_bus/reg_bus in, out_valid/out_ready/out_pc/out_addr/out_region handshake, align_err pulse)
module fetch_multi
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              N_SRC    = 2,
  parameter int              ISSUE    = 2,
  parameter int              QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              REGION_W = 4,
  localparam int             SW       = (clog2(N_SRC) > 1) ? clog2(N_SRC) : 1
) (
  input  logic                         reloj,
  input  logic                         reset,
  input  logic [1:0]                   sel_dir,
  input  logic [SW-1:0]                sel_src,
  input  logic [N_SRC*ADDR_W-1:0]      jump_bus,
  input  logic [N_SRC*ADDR_W-1:0]      reg_bus,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [ISSUE*ADDR_W-1:0]      out_addr,
  output logic [ISSUE*REGION_W-1:0]    out_region,
  output logic                         align_err
);
  localparam int CW = clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES * ISSUE);
  logic [ADDR_W-1:0] pc_q, pc_d, raw, head;
  logic align_q, align_d, redirect, pop, push_ok;
  logic [CW-1:0] count;
  logic [31:0] src;
  always_comb begin
    src = (32'(sel_src) < 32'(N_SRC)) ? 32'(sel_src) : '0;
    redirect = sel_dir != SEL_SEQ;
    raw = sel_dir == SEL_JUMP ? jump_bus[src*ADDR_W +: ADDR_W] :
          sel_dir == SEL_REG  ? reg_bus[src*ADDR_W +: ADDR_W] : RESET_PC;
    pop = out_valid & out_ready;
    push_ok = (count < CW'(QDEPTH)) | pop;
    pc_d = redirect ? {raw[ADDR_W-1:2], 2'b00} : push_ok ? pc_q + STEP : pc_q;
    align_d = (sel_dir == SEL_JUMP | sel_dir == SEL_REG) & (|raw[1:0]);
  end
  always_ff @(posedge reloj) begin
    if (reset) begin
      pc_q <= RESET_PC;
      align_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      align_q <= align_d;
    end
  end
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(QDEPTH)) u_fifo (
    .clk   (reloj),
    .rst   (reset),
    .flush (redirect),
    .push  (~redirect & push_ok),
    .pop   (pop),
    .din   (pc_q),
    .head  (head),
    .count (count)
  );
  assign out_valid = count != '0;
  assign out_pc = out_valid ? head : '0;
  assign align_err = align_q;
  for (genvar i = 0; i < ISSUE; i++) begin : g_slot
    logic [ADDR_W-1:0] a;
    assign a = out_valid ? head + ADDR_W'(INSTR_BYTES * i) : '0;
    assign out_addr[i*ADDR_W +: ADDR_W] = a;
    assign out_region[i*REGION_W +: REGION_W] = a[ADDR_W-1 -: REGION_W];
  end
endmodule

// File: tb/tb_fetch_multi.sv
// tb_fetch_multi: scoreboard bench for fetch_multi with directed redirect, back-pressure and wrap vectors
module tb_fetch_multi;
  localparam int ADDR_W = 32;
  localparam int N_SRC = 3;
  localparam int ISSUE = 2;
  localparam int REGION_W = 4;
  logic reloj = 1'b0;
  logic reset;
  logic [1:0] sel_dir;
  logic [1:0] sel_src;
  logic [N_SRC*ADDR_W-1:0] jump_bus, reg_bus;
  logic out_valid, out_ready, align_err;
  logic [ADDR_W-1:0] out_pc;
  logic [ISSUE*ADDR_W-1:0] out_addr;
  logic [ISSUE*REGION_W-1:0] out_region;
  logic [31:0] exp_q[$];
  logic [31:0] e, s1;
  int tests = 0;
  int fails = 0;
  always #5 reloj = ~reloj;
  fetch_multi #(
    .ADDR_W(ADDR_W), .N_SRC(N_SRC), .ISSUE(ISSUE), .QDEPTH(4),
    .RESET_PC(32'h0), .REGION_W(REGION_W)
  ) dut (
    .reloj(reloj), .reset(reset), .sel_dir(sel_dir), .sel_src(sel_src),
    .jump_bus(jump_bus), .reg_bus(reg_bus), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_addr(out_addr),
    .out_region(out_region), .align_err(align_err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge reloj);
      #1;
    end
  endtask
  always @(negedge reloj) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_head: got pc %h expected no handshake", out_pc);
      end else begin
        e = exp_q.pop_front();
        s1 = e + 32'd4;
        chk("head_pc", 64'(out_pc), 64'(e));
        chk("head_addr", out_addr, {s1, e});
        chk("head_region", 64'(out_region), 64'({s1[31:28], e[31:28]}));
      end
    end
  end
  initial begin
    reset = 1'b1; sel_dir = 2'b00; sel_src = 2'd0;
    jump_bus = '0; reg_bus = '0; out_ready = 1'b0;
    step(2);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_align", 64'(align_err), 0);
    chk("rst_pc", 64'(out_pc), 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_region", 64'(out_region), 0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h8); exp_q.push_back(32'h10);
    reset = 1'b0; out_ready = 1'b1;
    step(1);
    chk("seq_valid", 64'(out_valid), 1);
    chk("seq_first_pc", 64'(out_pc), 0);
    step(3);
    chk("seq_fourth_pc", 64'(out_pc), 64'h18);
    reset = 1'b1; out_ready = 1'b0;
    step(1);
    chk("rerst_valid", 64'(out_valid), 0);
    reset = 1'b0;
    step(8);
    chk("bp_valid", 64'(out_valid), 1);
    chk("bp_head", 64'(out_pc), 0);
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(k * 8));
    out_ready = 1'b1;
    step(6);
    jump_bus = {32'h2222_2220, 32'h1000_0040, 32'h0000_0004};
    sel_dir = 2'b01; sel_src = 2'd1; out_ready = 1'b0;
    step(1);
    chk("jmp_bubble", 64'(out_valid), 0);
    chk("jmp_align", 64'(align_err), 0);
    sel_dir = 2'b00; out_ready = 1'b1;
    exp_q.push_back(32'h1000_0040); exp_q.push_back(32'h1000_0048);
    step(1);
    chk("jmp_valid", 64'(out_valid), 1);
    chk("jmp_pc", 64'(out_pc), 64'h1000_0040);
    chk("jmp_region0", 64'(out_region[3:0]), 1);
    step(2);
    reg_bus = {32'h0000_7770, 32'h0000_5550, 32'h0000_0203};
    sel_dir = 2'b10; sel_src = 2'd3; out_ready = 1'b0;
    step(1);
    chk("mis_align_hi", 64'(align_err), 1);
    chk("mis_bubble", 64'(out_valid), 0);
    sel_dir = 2'b00;
    step(1);
    chk("mis_align_lo", 64'(align_err), 0);
    chk("mis_valid", 64'(out_valid), 1);
    chk("mis_pc", 64'(out_pc), 64'h200);
    jump_bus = {32'h2222_2220, 32'h1000_0042, 32'hFFFF_FFF8};
    sel_dir = 2'b01; sel_src = 2'd1;
    step(1);
    chk("dbl_first_align", 64'(align_err), 1);
    sel_src = 2'd0;
    step(1);
    chk("dbl_second_align", 64'(align_err), 0);
    chk("dbl_bubble", 64'(out_valid), 0);
    sel_dir = 2'b00;
    step(1);
    chk("wrap_valid", 64'(out_valid), 1);
    chk("wrap_addr", out_addr, {32'hFFFF_FFFC, 32'hFFFF_FFF8});
    chk("wrap_region", 64'(out_region), 64'hFF);
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'h0);
    out_ready = 1'b1;
    step(1);
    chk("wrap_next_pc", 64'(out_pc), 0);
    chk("wrap_next_region", 64'(out_region), 0);
    chk("wrap_next_addr", out_addr, {32'h4, 32'h0});
    step(1);
    out_ready = 1'b0;
    step(4);
    chk("full_head", 64'(out_pc), 64'h8);
    jump_bus = {32'h2222_2220, 32'h1000_0042, 32'h0000_0333};
    sel_dir = 2'b01; sel_src = 2'd0; reset = 1'b1;
    step(1);
    chk("rstmid_valid", 64'(out_valid), 0);
    chk("rstmid_align", 64'(align_err), 0);
    reset = 1'b0; sel_dir = 2'b00;
    step(1);
    chk("rstmid_align_after", 64'(align_err), 0);
    chk("rstmid_valid_after", 64'(out_valid), 1);
    chk("rstmid_pc", 64'(out_pc), 0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h8);
    out_ready = 1'b1;
    step(2);
    sel_dir = 2'b11; out_ready = 1'b0;
    step(1);
    chk("restart_bubble", 64'(out_valid), 0);
    chk("restart_align", 64'(align_err), 0);
    sel_dir = 2'b00;
    step(1);
    chk("restart_align_after", 64'(align_err), 0);
    chk("restart_valid", 64'(out_valid), 1);
    chk("restart_pc", 64'(out_pc), 0);
    step(1);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
